// File: rtl/test_monitor_if.sv
// CPU bus snoop interface for test_monitor: instruction-fetch PC and data-memory
// write port. The CPU side (or a bench) drives; the monitor only observes.
interface test_monitor_if;
  logic [31:0] i_mem_addr;
  logic [31:0] d_mem_addr;
  logic [31:0] d_mem_wdata;
  logic [3:0]  d_mem_wen;

  modport master (
    output i_mem_addr,
    output d_mem_addr,
    output d_mem_wdata,
    output d_mem_wen
  );

  modport slave (
    input i_mem_addr,
    input d_mem_addr,
    input d_mem_wdata,
    input d_mem_wen
  );
endinterface

// File: rtl/test_monitor.sv
// End-of-test monitor for RV32I simulation benches. Snoops fetch/data buses,
// decides PASS/FAIL from a full-word tohost write, flags TIMEOUT and PC HANG,
// counts RUN cycles and captures a signature memory region.
// Optional: define MON_TRACE_EN to print a line per status change and per
// tohost write; register behaviour is the same either way.
module test_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0FF0,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned HANG_LIMIT     = 64,
  parameter int unsigned CNT_W          = 32,
  parameter logic [31:0] SIG_BASE       = 32'h0000_0F00,
  parameter int unsigned SIG_DEPTH      = 16,
  localparam int unsigned IdxW          = $clog2(SIG_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  test_monitor_if.slave        bus,
  input  logic [IdxW-1:0]      sig_rd_idx,
  output logic [31:0]          sig_rd_data,
  output logic [2:0]           status,
  output logic                 done,
  output logic [30:0]          fail_code,
  output logic [CNT_W-1:0]     cycle_count
);

  typedef enum logic [2:0] {
    StRun     = 3'd0,
    StPass    = 3'd1,
    StFail    = 3'd2,
    StTimeout = 3'd3,
    StHang    = 3'd4
  } status_e;

  // One past the last signature byte; 33 bits so a region ending at 4 GiB works.
  localparam logic [32:0] SigEnd = {1'b0, SIG_BASE} + 33'(4 * SIG_DEPTH);

  status_e          status_q;
  logic             done_q;
  logic [30:0]      fail_code_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      prev_pc_q;
  logic [31:0]      same_q;
  logic [31:0]      sig_q [SIG_DEPTH];
  logic [31:0]      sig_rd_data_q;

  logic             tohost_hit;
  logic             tohost_full;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;
  logic             pc_same;
  logic [31:0]      same_d;
  logic             hang_hit;
  logic             sig_hit;
  logic [31:0]      sig_off;
  logic [IdxW-1:0]  sig_wr_idx;

  // Event decode for the current cycle's bus activity and counters.
  always_comb begin
    tohost_hit  = (bus.d_mem_wen != 4'b0000) &&
                  (bus.d_mem_addr[31:2] == TOHOST_ADDR[31:2]);
    tohost_full = (bus.d_mem_wen == 4'b1111);
    cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    pc_same     = (bus.i_mem_addr == prev_pc_q);
    same_d      = pc_same ? same_q + 32'd1 : 32'd0;
    hang_hit    = (HANG_LIMIT != 0) && pc_same && (same_d == HANG_LIMIT);
    sig_hit     = (bus.d_mem_wen != 4'b0000) && (bus.d_mem_addr >= SIG_BASE) &&
                  ({1'b0, bus.d_mem_addr} < SigEnd);
    sig_off     = bus.d_mem_addr - SIG_BASE;
    sig_wr_idx  = IdxW'(sig_off >> 2);
  end

  // Status FSM with counters; terminal states freeze everything until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q    <= StRun;
      done_q      <= 1'b0;
      fail_code_q <= 31'd0;
      cnt_q       <= '0;
      prev_pc_q   <= 32'hFFFF_FFFF;
      same_q      <= 32'd0;
    end else if (status_q == StRun) begin
      cnt_q     <= cnt_inc;
      prev_pc_q <= bus.i_mem_addr;
      same_q    <= same_d;
      // tohost beats timeout beats hang; a full-word write of 0 is a no-op.
      if (tohost_hit && !tohost_full) begin
        status_q    <= StFail;
        done_q      <= 1'b1;
        fail_code_q <= 31'h7FFF_FFFF;
      end else if (tohost_hit && bus.d_mem_wdata == 32'd1) begin
        status_q <= StPass;
        done_q   <= 1'b1;
      end else if (tohost_hit && bus.d_mem_wdata != 32'd0) begin
        status_q    <= StFail;
        done_q      <= 1'b1;
        fail_code_q <= bus.d_mem_wdata[31:1];
      end else if (timeout_hit) begin
        status_q <= StTimeout;
        done_q   <= 1'b1;
      end else if (hang_hit) begin
        status_q <= StHang;
        done_q   <= 1'b1;
      end
    end
  end

  // Signature capture (in every state) and registered read port (old data on
  // a same-cycle write to the read entry).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SIG_DEPTH); i++) sig_q[i] <= 32'd0;
      sig_rd_data_q <= 32'd0;
    end else begin
      sig_rd_data_q <= sig_q[sig_rd_idx];
      if (sig_hit) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.d_mem_wen[b]) sig_q[sig_wr_idx][8*b +: 8] <= bus.d_mem_wdata[8*b +: 8];
        end
      end
    end
  end

`ifdef MON_TRACE_EN
  logic [2:0] trace_last_q;

  // Report status changes (after they land) and every tohost write seen in RUN.
  always_ff @(posedge clk) begin
    trace_last_q <= status_q;
    if (!rst && status_q != trace_last_q)
      $display("%0t test_monitor: status=%0d fail_code=%h cycle_count=%0d",
               $time, status_q, fail_code_q, cnt_q);
    if (!rst && status_q == StRun && tohost_hit)
      $display("%0t test_monitor: tohost write wen=%b data=%h",
               $time, bus.d_mem_wen, bus.d_mem_wdata);
  end
`else
  // Tracing disabled: no display output.
`endif

  assign status      = status_q;
  assign done        = done_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cnt_q;
  assign sig_rd_data = sig_rd_data_q;

endmodule
